// File: rtl/motor_pkg.sv
// Shared types and constants for the BL-Ctrl motor update path.
package motor_pkg;
  localparam int NUM_MOTORS = 8;
  localparam int SPEED_W = 8;
  localparam int I2C_ADDR_W = 7;
  localparam int IDX_W = 3;
  localparam logic [I2C_ADDR_W-1:0] BLCTRL_BASE_ADDR = 7'h29;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    REQ,
    WAIT,
    NEXT,
    GAP
  } sched_state_t;

  // Address arithmetic wraps inside the 7-bit I2C address space.
  function automatic logic [I2C_ADDR_W-1:0] motor_addr(input logic [I2C_ADDR_W-1:0] base,
                                                       input logic [IDX_W-1:0] idx);
    return base + I2C_ADDR_W'(idx);
  endfunction
endpackage

// File: rtl/motor_stale_timer.sv
// Per-motor freshness timer: saturating counter cleared by each speed update,
// flags the motor stale once TIMEOUT_CYCLES pass without an update.
module motor_stale_timer #(
  parameter int TIMEOUT_CYCLES = 320000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_stale
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stale;

  // Out of reset every motor is treated as stale until its first update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= CNT_LAST;
      r_stale <= 1'b1;
    end else if (i_clear) begin
      r_cnt   <= '0;
      r_stale <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_stale <= 1'b1;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_stale = r_stale;
endmodule

// File: rtl/motor_update_scheduler.sv
// Round-robin scheduler feeding latched motor speeds to the BL-Ctrl I2C master.
// Define MOTOR_SCHED_RETRY_EN to retry NACKed writes up to MAX_RETRY times.
module motor_update_scheduler
  import motor_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] BASE_ADDR = BLCTRL_BASE_ADDR,
  parameter int TIMEOUT_CYCLES = 320000,
  parameter int FRAME_GAP_CYCLES = 16000
`ifdef MOTOR_SCHED_RETRY_EN
  , parameter int MAX_RETRY = 2
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          master_enable,
  input  logic [NUM_MOTORS-1:0]         motor_enable,
  input  logic [NUM_MOTORS*SPEED_W-1:0] speed_in_flat,
  input  logic [NUM_MOTORS-1:0]         speed_valid,
  output logic                          i2c_req,
  output logic [I2C_ADDR_W-1:0]         i2c_addr,
  output logic [SPEED_W-1:0]            i2c_data,
  input  logic                          i2c_ack,
  input  logic                          i2c_done,
  input  logic                          i2c_nack,
  output logic [IDX_W-1:0]              active_motor,
  output logic [NUM_MOTORS-1:0]         motor_stale,
  output logic [NUM_MOTORS-1:0]         nack_flags,
  output logic                          frame_done,
  output sched_state_t                  dbg_state
);
  localparam int GAP_W = (FRAME_GAP_CYCLES > 1) ? $clog2(FRAME_GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP_CYCLES - 1);
`ifdef MOTOR_SCHED_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] r_retry;
`endif

  sched_state_t          r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_req;
  logic [I2C_ADDR_W-1:0] r_addr;
  logic [SPEED_W-1:0]    r_data;
  logic                  r_frame_done;
  logic [NUM_MOTORS-1:0] r_nack;
  logic [GAP_W-1:0]      r_gap;
  logic [SPEED_W-1:0]    r_shadow [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] w_stale;
  logic                  w_found;
  logic [IDX_W-1:0]      w_pick;

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_timer
    motor_stale_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clear (speed_valid[g]),
      .o_stale (w_stale[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_MOTORS; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MOTORS; i++)
        if (speed_valid[i]) r_shadow[i] <= speed_in_flat[SPEED_W*i +: SPEED_W];
    end
  end

  // Lowest enabled motor at or after the current index.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_idx;
    for (int i = NUM_MOTORS - 1; i >= 0; i--) begin
      if (motor_enable[i] && (i >= int'(r_idx))) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(i);
      end
    end
  end

  // Handshake: i2c_req rises with addr/data already stable and holds until the
  // master pulses i2c_ack; completion is a later one-cycle i2c_done or i2c_nack,
  // with i2c_nack taking priority when both arrive together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      r_nack       <= '0;
      r_gap        <= '0;
`ifdef MOTOR_SCHED_RETRY_EN
      r_retry      <= '0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_idx <= '0;
`ifdef MOTOR_SCHED_RETRY_EN
          r_retry <= '0;
`endif
          if (master_enable) r_state <= SCAN;
        end
        SCAN: begin
          if (!master_enable) begin
            r_state <= IDLE;
          end else if (w_found) begin
            r_idx   <= w_pick;
            r_addr  <= motor_addr(BASE_ADDR, w_pick);
            r_data  <= w_stale[w_pick] ? '0 : r_shadow[w_pick];
            r_req   <= 1'b1;
            r_state <= REQ;
          end else begin
            r_idx        <= '0;
            r_gap        <= '0;
            r_frame_done <= 1'b1;
            r_state      <= GAP;
          end
        end
        REQ: begin
          // An ack in the same cycle as an enable drop commits the transfer.
          if (i2c_ack) begin
            r_req   <= 1'b0;
            r_state <= WAIT;
          end else if (!master_enable) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (i2c_nack) begin
`ifdef MOTOR_SCHED_RETRY_EN
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
              r_retry <= r_retry + RETRY_W'(1);
              r_req   <= 1'b1;
              r_state <= REQ;
            end else begin
              r_nack[r_idx] <= 1'b1;
              r_state       <= NEXT;
            end
`else
            r_nack[r_idx] <= 1'b1;
            r_state       <= NEXT;
`endif
          end else if (i2c_done) begin
            r_nack[r_idx] <= 1'b0;
            r_state       <= NEXT;
          end
        end
        NEXT: begin
`ifdef MOTOR_SCHED_RETRY_EN
          r_retry <= '0;
`endif
          if (!master_enable) begin
            r_state <= IDLE;
          end else if (r_idx == IDX_W'(NUM_MOTORS - 1)) begin
            r_idx        <= '0;
            r_gap        <= '0;
            r_frame_done <= 1'b1;
            r_state      <= GAP;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= SCAN;
          end
        end
        GAP: begin
          if (!master_enable) r_state <= IDLE;
          else if (r_gap == GAP_LAST) r_state <= SCAN;
          else r_gap <= r_gap + GAP_W'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign i2c_req      = r_req;
  assign i2c_addr     = r_addr;
  assign i2c_data     = r_data;
  assign active_motor = r_idx;
  assign motor_stale  = w_stale;
  assign nack_flags   = r_nack;
  assign frame_done   = r_frame_done;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_motor_update_scheduler.sv
// Scoreboard bench for motor_update_scheduler with an I2C master BFM and a
// frame-level reference model of the expected write sequence.
module tb_motor_update_scheduler;
  import motor_pkg::*;

  localparam int BASE = 'h29;
`ifdef MOTOR_SCHED_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif
  localparam logic [18:0] FRAME_MARK = 19'h40000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         master_enable;
  logic [7:0]   motor_enable;
  logic [63:0]  speed_in_flat;
  logic [7:0]   speed_valid;
  logic         i2c_req;
  logic [6:0]   i2c_addr;
  logic [7:0]   i2c_data;
  logic         i2c_ack;
  logic         i2c_done;
  logic         i2c_nack;
  logic [2:0]   active_motor;
  logic [7:0]   motor_stale;
  logic [7:0]   nack_flags;
  logic         frame_done;
  sched_state_t dbg_state;

  motor_update_scheduler #(
    .TIMEOUT_CYCLES   (100),
    .FRAME_GAP_CYCLES (20)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .master_enable (master_enable),
    .motor_enable  (motor_enable),
    .speed_in_flat (speed_in_flat),
    .speed_valid   (speed_valid),
    .i2c_req       (i2c_req),
    .i2c_addr      (i2c_addr),
    .i2c_data      (i2c_data),
    .i2c_ack       (i2c_ack),
    .i2c_done      (i2c_done),
    .i2c_nack      (i2c_nack),
    .active_motor  (active_motor),
    .motor_stale   (motor_stale),
    .nack_flags    (nack_flags),
    .frame_done    (frame_done),
    .dbg_state     (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [18:0] exp_q[$];
  logic [7:0]  spd [8];
  logic [7:0]  keep_mask = 8'h00;
  logic [7:0]  exp_nack = 8'h00;
  bit          bfm_hold = 1'b0;
  bit          bfm_both = 1'b0;
  int          bfm_nack_left = 0;
  logic [6:0]  bfm_nack_addr = 7'h00;
  int          bfm_xfer_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Speed source: presents spd[] and refreshes motors in keep_mask every 8 cycles.
  initial begin
    int tick;
    tick = 0;
    speed_valid = '0;
    speed_in_flat = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) speed_in_flat[8*i +: 8] = spd[i];
      tick++;
      speed_valid = (tick % 8 == 0) ? keep_mask : 8'h00;
    end
  end

  // I2C master BFM: ack one cycle after req, finish the transfer 3 cycles later.
  initial begin
    logic [6:0] cur;
    i2c_ack = 0;
    i2c_done = 0;
    i2c_nack = 0;
    forever begin
      @(negedge clk);
      i2c_ack = 0;
      i2c_done = 0;
      i2c_nack = 0;
      if (i2c_req && !bfm_hold && rst_n) begin
        cur = i2c_addr;
        i2c_ack = 1;
        @(negedge clk);
        i2c_ack = 0;
        repeat (2) @(negedge clk);
        if (bfm_nack_left > 0 && cur == bfm_nack_addr) begin
          bfm_nack_left--;
          i2c_nack = 1;
          i2c_done = bfm_both;
        end else begin
          i2c_done = 1;
        end
        bfm_xfer_cnt++;
      end
    end
  end

  task automatic sb_compare(input string name, input logic [18:0] obs);
    logic [18:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $display("FAIL %s: got unexpected %0h expected nothing (t=%0t)", name, obs, $time);
    end else begin
      e = exp_q.pop_front();
      if (obs !== e) begin
        n_errors++;
        $display("FAIL %s: got %0h expected %0h (t=%0t)", name, obs, e, $time);
      end
    end
  endtask

  // Monitor: every new request and every frame_done pulse consumes one expectation.
  initial begin
    bit prev_req;
    prev_req = 0;
    forever begin
      @(negedge clk);
      if (frame_done) sb_compare("frame_done", FRAME_MARK);
      if (i2c_req && !prev_req) sb_compare("write", {1'b0, active_motor, i2c_addr, i2c_data});
      prev_req = i2c_req;
    end
  end

  // Reference model: one frame is every enabled motor in index order, stale -> 0,
  // NACKed motors repeated once per attempt, then the frame marker.
  task automatic push_frame(input logic [7:0] en);
    for (int i = 0; i < 8; i++) begin
      if (en[i]) begin
        logic [6:0] a;
        logic [7:0] d;
        int att;
        bit last_nack;
        a = 7'(BASE + i);
        d = keep_mask[i] ? spd[i] : 8'h00;
        att = 1;
        last_nack = 0;
        if (bfm_nack_left > 0 && a == bfm_nack_addr) begin
          att = (bfm_nack_left > RETRIES) ? RETRIES + 1 : bfm_nack_left + 1;
          last_nack = (bfm_nack_left > RETRIES);
        end
        for (int k = 0; k < att; k++) exp_q.push_back({1'b0, 3'(i), a, d});
        exp_nack[i] = last_nack;
      end
    end
    exp_q.push_back(FRAME_MARK);
  endtask

  task automatic wait_frame_done();
    bit seen;
    seen = 0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (frame_done) seen = 1;
    end
    if (!seen) check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_req();
    bit seen;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (i2c_req) seen = 1;
    end
    if (!seen) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] en);
    motor_enable = en;
    push_frame(en);
    master_enable = 1;
    wait_frame_done();
    check("nack_flags", nack_flags, exp_nack);
    bfm_nack_left = 0;
    bfm_both = 0;
  endtask

  initial begin
    int xfers;
    bit seen;
    rst_n = 0;
    master_enable = 0;
    motor_enable = 8'hFF;
    for (int i = 0; i < 8; i++) spd[i] = 8'(8'h10 * i);
    repeat (3) @(negedge clk);
    check("rst_req", i2c_req, 0);
    check("rst_addr", i2c_addr, 0);
    check("rst_data", i2c_data, 0);
    check("rst_active", active_motor, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_nack", nack_flags, 0);
    check("rst_stale", motor_stale, 8'hFF);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1;
    keep_mask = 8'hFF;
    repeat (12) @(negedge clk);
    check("fresh_after_update", motor_stale, 8'h00);

    // All motors, speeds 0x10*i, then a pattern mask and random frames.
    run_frame(8'hFF);
    run_frame(8'b0010_0101);
    run_frame(8'b0010_0101);
    run_frame(8'h00);
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) spd[i] = 8'($urandom_range(0, 255));
      run_frame(8'($urandom_range(0, 255)));
    end

    // NACK handling on address 0x2A, then combined done+nack, then repeated NACKs.
    bfm_nack_addr = 7'h2A;
    bfm_nack_left = 1;
    run_frame(8'hFF);
    bfm_nack_left = 1;
    bfm_both = 1;
    run_frame(8'hFF);
    bfm_nack_left = 3;
    run_frame(8'hFF);
    run_frame(8'hFF);

    // Motor 3 stops updating: goes stale, sends 0, recovers with 0x55.
    master_enable = 0;
    keep_mask = 8'hF7;
    repeat (120) @(negedge clk);
    check("stale_set", motor_stale, 8'h08);
    run_frame(8'hFF);
    spd[3] = 8'h55;
    keep_mask = 8'hFF;
    motor_enable = 8'hFF;
    push_frame(8'hFF);
    repeat (10) @(negedge clk);
    check("stale_clear", motor_stale, 8'h00);
    wait_frame_done();
    master_enable = 0;
    repeat (3) @(negedge clk);
    check("idle_after_disable", dbg_state, IDLE);

    // Enable drop while waiting for completion: transfer finishes, no further writes.
    xfers = bfm_xfer_cnt;
    exp_q.push_back({1'b0, 3'd0, 7'h29, spd[0]});
    master_enable = 1;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk);
      if (i2c_ack) seen = 1;
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
    @(negedge clk);
    master_enable = 0;
    repeat (10) @(negedge clk);
    check("wait_drop_state", dbg_state, IDLE);
    check("wait_drop_req", i2c_req, 0);
    check("wait_drop_xfer", 32'(bfm_xfer_cnt), 32'(xfers + 1));

    // Enable drop while requesting: req falls on the next cycle.
    bfm_hold = 1;
    exp_q.push_back({1'b0, 3'd0, 7'h29, spd[0]});
    master_enable = 1;
    wait_req();
    master_enable = 0;
    @(negedge clk);
    check("req_drop_req", i2c_req, 0);
    check("req_drop_state", dbg_state, IDLE);

    // Reset during a request, then the first frame carries all zeros.
    exp_q.push_back({1'b0, 3'd0, 7'h29, spd[0]});
    master_enable = 1;
    wait_req();
    #2;
    rst_n = 0;
    keep_mask = 8'h00;
    master_enable = 0;
    #1;
    check("async_rst_req", i2c_req, 0);
    check("async_rst_stale", motor_stale, 8'hFF);
    check("async_rst_nack", nack_flags, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    bfm_hold = 0;
    exp_nack = 8'h00;
    run_frame(8'hFF);
    master_enable = 0;
    repeat (30) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
